// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded operations over a valid/ready handshake,
// packs each one into a 32-bit instruction word and writes it to consecutive
// instruction-memory addresses starting at base_addr.
//
// Build option: define LOAD_NOP_EN to follow every LW with one NOP word (32'd0)
// at the next address, covering the load-use slot. Without it the NOP state is
// not built and no padding words are ever written.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [4:0]        op_rs,
  input  logic [4:0]        op_rt,
  input  logic [4:0]        op_rd,
  input  logic [15:0]       op_imm,
  output logic              im_we,
  input  logic              im_ready,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  // Operation codes on op_code
  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpMul = 3'd4;
  localparam logic [2:0] OpLw  = 3'd5;
  localparam logic [2:0] OpSw  = 3'd6;
  localparam logic [2:0] OpIll = 3'd7;

  // Instruction word fields
  localparam logic [5:0] OpcAlu   = 6'd4;
  localparam logic [5:0] OpcLw    = 6'd5;
  localparam logic [5:0] OpcSw    = 6'd6;
  localparam logic [4:0] AluShamt = 5'd10;
  localparam logic [5:0] FnAdd    = 6'd32;
  localparam logic [5:0] FnSub    = 6'd34;
  localparam logic [5:0] FnAnd    = 6'd36;
  localparam logic [5:0] FnOr     = 6'd37;
  localparam logic [5:0] FnMul    = 6'd50;
  localparam logic [31:0] NopWord = 32'd0;

  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrLast = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   CountOne = (ADDR_W + 1)'(1);

`ifdef LOAD_NOP_EN
  typedef enum logic [1:0] {StIdle, StEmit, StNop, StFull} state_e;
`else
  typedef enum logic [1:0] {StIdle, StEmit, StFull} state_e;
`endif

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                active_q;
`ifdef LOAD_NOP_EN
  logic                lw_q, lw_d;
`endif

  logic xfer;
  logic legal;
  logic at_last;

  // Pack one operation into its instruction word; illegal codes never reach memory.
  function automatic logic [31:0] encode(input logic [2:0]  code,
                                         input logic [4:0]  rs,
                                         input logic [4:0]  rt,
                                         input logic [4:0]  rd,
                                         input logic [15:0] imm);
    logic [31:0] w;
    w = NopWord;
    unique case (code)
      OpAdd:   w = {OpcAlu, rs, rt, rd, AluShamt, FnAdd};
      OpSub:   w = {OpcAlu, rs, rt, rd, AluShamt, FnSub};
      OpAnd:   w = {OpcAlu, rs, rt, rd, AluShamt, FnAnd};
      OpOr:    w = {OpcAlu, rs, rt, rd, AluShamt, FnOr};
      OpMul:   w = {OpcAlu, rs, rt, rd, AluShamt, FnMul};
      OpLw:    w = {OpcLw, rs, rt, imm};
      OpSw:    w = {OpcSw, rs, rt, imm};
      default: w = NopWord;
    endcase
    return w;
  endfunction

  // Hold op_ready low until the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  // op_ready is forced low while start is high so a restart never swallows a request.
  assign op_ready = active_q && (state_q == StIdle) && !start;
  assign xfer     = op_valid && op_ready;
  assign legal    = (op_code != OpIll);
  assign at_last  = (addr_q == AddrLast);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef LOAD_NOP_EN
      lw_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef LOAD_NOP_EN
      lw_q    <= lw_d;
`endif
    end
  end

  // Next-state: start overrides everything, otherwise advance the write sequence.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    err_d   = err_q;
`ifdef LOAD_NOP_EN
    lw_d    = lw_q;
`endif

    if (start) begin
      // Any pending write is abandoned; im_we drops because the state leaves EMIT.
      state_d = StIdle;
      addr_d  = base_addr;
      count_d = '0;
      err_d   = 1'b0;
`ifdef LOAD_NOP_EN
      lw_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (xfer) begin
            if (legal) begin
              data_d  = encode(op_code, op_rs, op_rt, op_rd, op_imm);
              state_d = StEmit;
`ifdef LOAD_NOP_EN
              lw_d    = (op_code == OpLw);
`endif
            end else begin
              // Illegal requests are consumed so the producer is not stalled.
              err_d = 1'b1;
            end
          end
        end

        StEmit: begin
          if (im_ready) begin
            count_d = count_q + CountOne;
            if (at_last) begin
              // Last address used: a pending NOP is dropped, address does not wrap.
              state_d = StFull;
            end else begin
              addr_d  = addr_q + AddrOne;
`ifdef LOAD_NOP_EN
              if (lw_q) begin
                state_d = StNop;
                data_d  = NopWord;
              end else begin
                state_d = StIdle;
              end
`else
              state_d = StIdle;
`endif
            end
          end
        end

`ifdef LOAD_NOP_EN
        StNop: begin
          if (im_ready) begin
            count_d = count_q + CountOne;
            lw_d    = 1'b0;
            if (at_last) begin
              state_d = StFull;
            end else begin
              addr_d  = addr_q + AddrOne;
              state_d = StIdle;
            end
          end
        end
`endif

        StFull: begin
          state_d = StFull;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Outputs come straight from registers so they are stable across a stalled write.
  always_comb begin
`ifdef LOAD_NOP_EN
    im_we = (state_q == StEmit) || (state_q == StNop);
`else
    im_we = (state_q == StEmit);
`endif
    im_addr = addr_q;
    im_data = data_q;
    count   = count_q;
    full    = (state_q == StFull);
    err     = err_q;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (ADDR_W=2): stimulus pushes the expected
// {addr, data} of each write, a negedge monitor pops and compares on every
// completed memory write and checks that stalled writes hold steady.
module tb_instr_encoder;

  localparam int unsigned AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          op_valid;
  logic          op_ready;
  logic [2:0]    op_code;
  logic [4:0]    op_rs;
  logic [4:0]    op_rt;
  logic [4:0]    op_rd;
  logic [15:0]   op_imm;
  logic          im_we;
  logic          im_ready;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_data;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  int tests = 0;
  int fails = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;
  logic           holding = 1'b0;
  logic [AW-1:0]  hold_addr;
  logic [31:0]    hold_data;
  int             exp_count;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_rs     (op_rs),
    .op_rt     (op_rt),
    .op_rd     (op_rd),
    .op_imm    (op_imm),
    .im_we     (im_we),
    .im_ready  (im_ready),
    .im_addr   (im_addr),
    .im_data   (im_data),
    .count     (count),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: compare every completed write against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      holding = 1'b0;
    end else begin
      if (holding && im_we) begin
        check("stall_addr_stable", 32'(im_addr), 32'(hold_addr));
        check("stall_data_stable", im_data, hold_data);
      end
      if (im_we && im_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, expected no write",
                   im_addr, im_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("wr_addr", 32'(im_addr), 32'(exp_e[AW+31:32]));
          check("wr_data", im_data, exp_e[31:0]);
        end
      end
      holding   = im_we && !im_ready && !start;
      hold_addr = im_addr;
      hold_data = im_data;
    end
  end

  // Present one request and wait (bounded) for it to transfer. Called at posedge+1.
  task automatic send(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm);
    bit done;
    done     = 1'b0;
    op_valid = 1'b1;
    op_code  = c;
    op_rs    = rs;
    op_rt    = rt;
    op_rd    = rd;
    op_imm   = imm;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (op_ready) done = 1'b1;
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: op_ready 0, expected 1 within 20 cycles");
    end
  endtask

  // Wait (bounded) until no write is pending, then realign to posedge+1.
  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < 50 && !idle; n++) begin
      @(negedge clk);
      if (!im_we) idle = 1'b1;
    end
    if (!idle) begin
      tests++;
      fails++;
      $display("FAIL write_timeout: im_we 1, expected 0 within 50 cycles");
    end
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse with a competing request that must not be accepted.
  task automatic pulse_start(input logic [AW-1:0] base);
    base_addr = base;
    start     = 1'b1;
    op_valid  = 1'b1;
    op_code   = 3'd0;
    #1;
    check("op_ready_during_start", 32'(op_ready), 32'd0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    op_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    op_valid  = 1'b0;
    op_code   = '0;
    op_rs     = '0;
    op_rt     = '0;
    op_rd     = '0;
    op_imm    = '0;
    im_ready  = 1'b1;

    // Reset values while rst_n is low
    repeat (2) @(posedge clk);
    #1;
    check("rst_op_ready", 32'(op_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_data", im_data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    #1;
    check("op_ready_before_first_edge", 32'(op_ready), 32'd0);
    @(posedge clk);
    #1;
    check("op_ready_after_first_edge", 32'(op_ready), 32'd1);

    // ADD rs=1 rt=2 rd=3 at base 0, latency 1
    pulse_start(2'd0);
    push(2'd0, 32'h10221AA0);
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    check("add_we_latency", 32'(im_we), 32'd1);
    check("add_im_data", im_data, 32'h10221AA0);
    @(posedge clk);
    #1;
    check("add_count", 32'(count), 32'd1);
    check("add_we_drop", 32'(im_we), 32'd0);

    // LW rs=4 rt=5 imm=0x10 with im_ready low for 3 cycles
    im_ready = 1'b0;
    push(2'd1, 32'h14850010);
`ifdef LOAD_NOP_EN
    push(2'd2, 32'h00000000);
    exp_count = 3;
`else
    exp_count = 2;
`endif
    send(3'd5, 5'd4, 5'd5, 5'd0, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      check("lw_stall_op_ready", 32'(op_ready), 32'd0);
      check("lw_stall_we", 32'(im_we), 32'd1);
      check("lw_stall_data", im_data, 32'h14850010);
      @(posedge clk);
      #1;
    end
    im_ready = 1'b1;
    wait_idle();
    check("lw_count", 32'(count), 32'(exp_count));

    // Illegal op: consumed, err set, no write
    send(3'd7, 5'd1, 5'd1, 5'd1, 16'h0);
    check("ill_err", 32'(err), 32'd1);
    check("ill_op_ready", 32'(op_ready), 32'd1);
    check("ill_no_we", 32'(im_we), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("ill_count", 32'(count), 32'(exp_count));

    // Restart at base 2: err cleared, two SW fill the memory
    pulse_start(2'd2);
    check("start_err_clr", 32'(err), 32'd0);
    check("start_count_clr", 32'(count), 32'd0);
    check("start_addr", 32'(im_addr), 32'd2);
    push(2'd2, 32'h18E8BEEF);
    send(3'd6, 5'd7, 5'd8, 5'd0, 16'hBEEF);
    wait_idle();
    check("sw1_full", 32'(full), 32'd0);
    push(2'd3, 32'h18221234);
    send(3'd6, 5'd1, 5'd2, 5'd0, 16'h1234);
    wait_idle();
    check("sw_full", 32'(full), 32'd1);
    check("sw_full_op_ready", 32'(op_ready), 32'd0);
    check("sw_count", 32'(count), 32'd2);
    // A third request must stay pending
    op_valid = 1'b1;
    op_code  = 3'd0;
    repeat (5) @(posedge clk);
    #1;
    check("full_op_ready_held", 32'(op_ready), 32'd0);
    op_valid = 1'b0;
    check("full_count_held", 32'(count), 32'd2);
    check("full_addr_nowrap", 32'(im_addr), 32'd3);

    // Start while a write is stalled abandons it
    pulse_start(2'd0);
    im_ready = 1'b0;
    send(3'd1, 5'd3, 5'd4, 5'd5, 16'h0);
    check("sub_we", 32'(im_we), 32'd1);
    check("sub_data", im_data, 32'h10642AA2);
    @(posedge clk);
    #1;
    pulse_start(2'd1);
    check("abandon_we", 32'(im_we), 32'd0);
    check("abandon_addr", 32'(im_addr), 32'd1);
    check("abandon_count", 32'(count), 32'd0);
    im_ready = 1'b1;

    // AND / OR / MUL from base 1 up to the last address
    push(2'd1, 32'h100002A4);
    send(3'd2, 5'd0, 5'd0, 5'd0, 16'h0);
    wait_idle();
    push(2'd2, 32'h100002A5);
    send(3'd3, 5'd0, 5'd0, 5'd0, 16'h0);
    wait_idle();
    push(2'd3, 32'h13FFFAB2);
    send(3'd4, 5'd31, 5'd31, 5'd31, 16'h0);
    wait_idle();
    check("base1_count", 32'(count), 32'd3);
    check("base1_full", 32'(full), 32'd1);

    // Asynchronous reset in the middle of a stalled write
    pulse_start(2'd0);
    im_ready = 1'b0;
    send(3'd0, 5'd1, 5'd2, 5'd3, 16'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 32'(im_we), 32'd0);
    check("async_rst_data", im_data, 32'd0);
    check("async_rst_addr", 32'(im_addr), 32'd0);
    check("async_rst_op_ready", 32'(op_ready), 32'd0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_full", 32'(full), 32'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    im_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
